// File: rtl/cpu0_mem_arbiter.sv
// Round-robin arbiter that lets the CPU0 instruction-fetch and data ports share one byte-wide,
// 1-cycle synchronous-read memory, moving one 32-bit big-endian word per granted request.
module cpu0_mem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  // Request/ack handshake: a port raises req with stable addr/data and holds it until its
  // one-cycle ack; requests are sampled only in IDLE, so a req still high after ack is a new one.
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [7:0]        m_wdata,
  input  logic [7:0]        m_rdata,
  output logic              busy,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WAIT = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;
  logic              r_last;
  logic [ADDR_W-1:0] r_base;
  logic              r_we;
  logic [31:0]       r_wdata;
  logic [1:0]        r_cnt;
  logic [31:8]       r_rbuf;
  logic [31:0]       r_i_rdata;
  logic [31:0]       r_d_rdata;

  logic              w_any_req;
  logic              w_grant_d;
  logic              w_xfer;
  logic [4:0]        w_cap_lsb;
  logic [7:0]        w_wbyte;

  assign w_any_req = i_req | d_req;
  // On a tie the port that was not served last wins.
  assign w_grant_d = d_req & (~i_req | (r_last == OWN_I));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_any_req) w_next = S_XFER;
      S_XFER: if (r_cnt == 2'd3) w_next = r_we ? S_ACK : S_WAIT;
      S_WAIT: w_next = S_ACK;
      S_ACK:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Byte k arrives one cycle after its issue, i.e. while cnt == k+1 (or in WAIT for k == 3).
  assign w_cap_lsb = 5'd24 - {r_cnt - 2'd1, 3'b000};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_owner   <= OWN_I;
      r_last    <= OWN_D;
      r_base    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_rbuf    <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_grant_d;
            r_last  <= w_grant_d;
            r_base  <= w_grant_d ? d_addr : i_addr;
            r_we    <= w_grant_d & d_we;
            r_wdata <= w_grant_d ? d_wdata : '0;
            r_cnt   <= '0;
          end
        end
        S_XFER: begin
          r_cnt <= r_cnt + 2'd1;
          if (!r_we && (r_cnt != 2'd0)) r_rbuf[w_cap_lsb +: 8] <= m_rdata;
        end
        S_WAIT: begin
          if (r_owner == OWN_D) r_d_rdata <= {r_rbuf, m_rdata};
          else                  r_i_rdata <= {r_rbuf, m_rdata};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_wbyte = r_wdata[31:24];
    case (r_cnt)
      2'd0: w_wbyte = r_wdata[31:24];
      2'd1: w_wbyte = r_wdata[23:16];
      2'd2: w_wbyte = r_wdata[15:8];
      2'd3: w_wbyte = r_wdata[7:0];
      default: w_wbyte = r_wdata[31:24];
    endcase
  end

  // Memory-side outputs are forced to zero outside XFER so idle/reset values are clean.
  assign w_xfer      = (r_state == S_XFER);
  assign m_en        = w_xfer;
  assign m_we        = w_xfer & r_we;
  assign m_addr      = w_xfer ? (r_base + {{(ADDR_W-2){1'b0}}, r_cnt}) : '0;
  assign m_wdata     = w_xfer ? w_wbyte : 8'h00;
  assign i_ack       = (r_state == S_ACK) && (r_owner == OWN_I);
  assign d_ack       = (r_state == S_ACK) && (r_owner == OWN_D);
  assign i_rdata     = r_i_rdata;
  assign d_rdata     = r_d_rdata;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cpu0_mem_arbiter.sv
// Directed bench for cpu0_mem_arbiter: byte memory model, per-scenario tasks with inline checks.
module tb_cpu0_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        i_req;
  logic [7:0]  i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_en;
  logic        m_we;
  logic [7:0]  m_addr;
  logic [7:0]  m_wdata;
  logic [7:0]  m_rdata;
  logic        busy;
  logic [1:0]  dbg_state;

  logic [7:0]  mem [256];
  logic [16:0] log_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clock = ~clock;

  cpu0_mem_arbiter #(.ADDR_W(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  // Byte memory with 1-cycle synchronous read; every access is logged as {we, addr, wdata}.
  always @(posedge clock) begin
    if (m_en) begin
      log_q.push_back({m_we, m_addr, m_wdata});
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_ack(input bit port_d, input int budget, output int cycles, output bit other_seen);
    bit done;
    done = 1'b0;
    cycles = 0;
    other_seen = 1'b0;
    while (!done && cycles < budget) begin
      @(negedge clock);
      cycles++;
      if (port_d ? i_ack : d_ack) other_seen = 1'b1;
      if (port_d ? d_ack : i_ack) done = 1'b1;
    end
    if (!done) cycles = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    m_rdata = '0;
    repeat (3) @(negedge clock);
    n_tests++;
    if ({m_en, m_we, m_addr, m_wdata, i_ack, d_ack, i_rdata, d_rdata, busy} !== 85'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {m_en, m_we, m_addr, m_wdata, i_ack, d_ack, i_rdata, d_rdata, busy});
    end
    reset_n = 1'b1;
    @(negedge clock);
    n_tests++;
    if (busy !== 1'b0 || dbg_state !== 2'd0 || m_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b state=%0d m_en=%b required 0 0 0", busy, dbg_state, m_en);
    end
  endtask

  task automatic test_ifetch();
    int cyc;
    bit oth;
    bit ok;
    mem[8'h00] = 8'h00; mem[8'h01] = 8'h1F; mem[8'h02] = 8'h00; mem[8'h03] = 8'h18;
    log_q.delete();
    i_addr = 8'h00; i_req = 1'b1;
    wait_ack(1'b0, 20, cyc, oth);
    i_req = 1'b0;
    n_tests++;
    if (cyc !== 6) begin n_fail++; $display("FAIL ifetch_latency: got %0d required 6", cyc); end
    n_tests++;
    if (i_rdata !== 32'h001F0018) begin n_fail++; $display("FAIL ifetch_rdata: got %h required 001f0018", i_rdata); end
    n_tests++;
    if (oth !== 1'b0) begin n_fail++; $display("FAIL ifetch_no_dack: got d_ack seen=%b required 0", oth); end
    ok = (log_q.size() == 4);
    for (int k = 0; k < 4; k++)
      if (ok && (log_q[k][16] !== 1'b0 || log_q[k][15:8] !== 8'(k))) ok = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL ifetch_addr_seq: got %0d accesses, sequence wrong, required reads 00..03", log_q.size()); end
    @(negedge clock);
    n_tests++;
    if (i_ack !== 1'b0 || i_rdata !== 32'h001F0018) begin
      n_fail++; $display("FAIL ifetch_pulse_hold: got ack=%b rdata=%h required 0 001f0018", i_ack, i_rdata);
    end
  endtask

  task automatic test_write_read();
    int cyc;
    bit oth;
    bit ok;
    logic [7:0] exp_b [4];
    exp_b = '{8'h00, 8'h00, 8'h00, 8'h37};
    log_q.delete();
    d_we = 1'b1; d_addr = 8'h20; d_wdata = 32'h00000037; d_req = 1'b1;
    wait_ack(1'b1, 20, cyc, oth);
    d_req = 1'b0;
    n_tests++;
    if (cyc !== 5) begin n_fail++; $display("FAIL write_latency: got %0d required 5", cyc); end
    ok = (log_q.size() == 4);
    for (int k = 0; k < 4; k++)
      if (ok && log_q[k] !== {1'b1, 8'h20 + 8'(k), exp_b[k]}) ok = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL write_bytes: got %0d accesses, sequence wrong, required 00 00 00 37 at 20..23", log_q.size()); end
    n_tests++;
    if ({mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]} !== 32'h00000037) begin
      n_fail++; $display("FAIL write_mem: got %h required 00000037", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]});
    end
    @(negedge clock);
    d_we = 1'b0; d_req = 1'b1;
    wait_ack(1'b1, 20, cyc, oth);
    d_req = 1'b0;
    n_tests++;
    if (cyc !== 6 || d_rdata !== 32'h00000037) begin
      n_fail++; $display("FAIL readback: got lat=%0d rdata=%h required 6 00000037", cyc, d_rdata);
    end
    n_tests++;
    if (i_rdata !== 32'h001F0018) begin n_fail++; $display("FAIL readback_irdata: got %h required 001f0018", i_rdata); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int   n_ack;
    logic [3:0] order;
    int   stamp [4];
    reset_n = 1'b0; @(negedge clock); reset_n = 1'b1; @(negedge clock);
    i_addr = 8'h00; d_addr = 8'h20; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    n_ack = 0; order = '0;
    for (int n = 1; n <= 60 && n_ack < 4; n++) begin
      @(negedge clock);
      if (i_ack || d_ack) begin
        order[n_ack] = d_ack;
        stamp[n_ack] = n;
        n_ack++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    n_tests++;
    if (n_ack !== 4 || order !== 4'b1010) begin
      n_fail++; $display("FAIL tie_order: got %0d acks order=%b required 4 acks order=1010 (I,D,I,D)", n_ack, order);
    end
    n_tests++;
    if (n_ack != 4 || stamp[0] != 6 || stamp[1] != 13 || stamp[2] != 20 || stamp[3] != 27) begin
      n_fail++; $display("FAIL tie_spacing: got %0d %0d %0d %0d required 6 13 20 27",
                         stamp[0], stamp[1], stamp[2], stamp[3]);
    end
    n_tests++;
    if (i_rdata !== 32'h001F0018 || d_rdata !== 32'h00000037) begin
      n_fail++; $display("FAIL tie_rdata: got %h %h required 001f0018 00000037", i_rdata, d_rdata);
    end
    @(negedge clock);
  endtask

  task automatic test_wrap();
    int cyc;
    bit oth;
    bit ok;
    logic [7:0] exp_a [4];
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB; mem[8'h00] = 8'hCC; mem[8'h01] = 8'hDD;
    log_q.delete();
    d_we = 1'b0; d_addr = 8'hFE; d_req = 1'b1;
    wait_ack(1'b1, 20, cyc, oth);
    d_req = 1'b0;
    n_tests++;
    if (cyc !== 6 || d_rdata !== 32'hAABBCCDD) begin
      n_fail++; $display("FAIL wrap_rdata: got lat=%0d rdata=%h required 6 aabbccdd", cyc, d_rdata);
    end
    ok = (log_q.size() == 4);
    for (int k = 0; k < 4; k++)
      if (ok && log_q[k][15:8] !== exp_a[k]) ok = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL wrap_addr_seq: got %0d accesses, sequence wrong, required fe ff 00 01", log_q.size()); end
    @(negedge clock);
  endtask

  task automatic test_change_mid();
    int cyc;
    bit oth;
    bit ok;
    logic [7:0] exp_b [4];
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    log_q.delete();
    d_we = 1'b1; d_addr = 8'h40; d_wdata = 32'hA1B2C3D4; d_req = 1'b1;
    repeat (2) @(negedge clock);
    d_addr = 8'h80; d_wdata = 32'hFFFFFFFF;
    wait_ack(1'b1, 20, cyc, oth);
    d_req = 1'b0;
    n_tests++;
    if (cyc + 2 !== 5) begin n_fail++; $display("FAIL midchange_latency: got %0d required 5", cyc + 2); end
    ok = (log_q.size() == 4);
    for (int k = 0; k < 4; k++)
      if (ok && log_q[k] !== {1'b1, 8'h40 + 8'(k), exp_b[k]}) ok = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL midchange_bytes: got %0d accesses, sequence wrong, required a1 b2 c3 d4 at 40..43", log_q.size()); end
    n_tests++;
    if ({mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} !== 32'hA1B2C3D4) begin
      n_fail++; $display("FAIL midchange_mem: got %h required a1b2c3d4", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]});
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit oth;
    int acks;
    mem[8'h10] = 8'h55; mem[8'h11] = 8'h66; mem[8'h12] = 8'h77; mem[8'h13] = 8'h88;
    d_we = 1'b1; d_addr = 8'h10; d_wdata = 32'h11223344; d_req = 1'b1;
    repeat (2) @(negedge clock);
    @(posedge clock);
    #2;
    reset_n = 1'b0; d_req = 1'b0;
    #1;
    n_tests++;
    if ({m_en, m_we, m_addr, m_wdata, i_ack, d_ack, i_rdata, d_rdata, busy} !== 85'd0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h required 0",
                         {m_en, m_we, m_addr, m_wdata, i_ack, d_ack, i_rdata, d_rdata, busy});
    end
    @(negedge clock);
    reset_n = 1'b1;
    n_tests++;
    if ({mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]} !== 32'h11227788) begin
      n_fail++; $display("FAIL midreset_mem: got %h required 11227788", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]});
    end
    acks = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      if (i_ack || d_ack) acks++;
    end
    n_tests++;
    if (acks !== 0) begin n_fail++; $display("FAIL midreset_no_ack: got %0d acks required 0", acks); end
    i_addr = 8'h00; d_addr = 8'h20; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    wait_ack(1'b0, 20, cyc, oth);
    i_req = 1'b0; d_req = 1'b0;
    n_tests++;
    if (cyc !== 6 || oth !== 1'b0) begin
      n_fail++; $display("FAIL midreset_tie: got lat=%0d d_first=%b required 6 0", cyc, oth);
    end
    n_tests++;
    if (i_rdata !== 32'hCCDD0018) begin n_fail++; $display("FAIL midreset_irdata: got %h required ccdd0018", i_rdata); end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_write_read();
    test_back_to_back();
    test_wrap();
    test_change_mid();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
